// File: rtl/bluejay_pkg.sv
// Shared state encoding and width helper for the bluejay panel streamer.
package bluejay_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_LINE = 3'd1,
      ST_SYNC      = 3'd2,
      ST_STREAM    = 3'd3,
      ST_LINE_END  = 3'd4,
      ST_UPDATE    = 3'd5
   } state_t;

   // Bits needed to hold 0..n-1, never less than one.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned w;
      w = 1;
      for (int unsigned i = 1; i < 32; i++) begin
         if ((64'd1 << i) < 64'(n)) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/bluejay_counter.sv
// Modulo counter with synchronous clear, enable and a terminal-count flag.
module bluejay_counter
   import bluejay_pkg::*;
#(
   parameter int unsigned MODULO = 4,
   parameter int unsigned W      = clog2(MODULO)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         term
);

   assign term = (count == W'(MODULO - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= term ? '0 : count + W'(1);
      end
   end

endmodule

// File: rtl/bluejay_stream.sv
// Streams FWFT FIFO words to a line-oriented panel with line sync and frame update strobes.
module bluejay_stream
   import bluejay_pkg::*;
#(
   parameter int unsigned DATA_W          = 32,
   parameter int unsigned WORDS_PER_LINE  = 40,
   parameter int unsigned LINES_PER_FRAME = 1024
) (
   input  logic                               clk_i,
   input  logic                               reset_i,
   input  logic                               new_frame_i,
   input  logic                               invert_i,
   input  logic [DATA_W-1:0]                  data_i,
   input  logic                               fifo_empty_i,
   input  logic                               next_line_rdy_i,
   output logic                               get_next_word_o,
   output logic [DATA_W-1:0]                  data_o,
   output logic                               valid_o,
   output logic                               sync_o,
   output logic                               update_o,
   output logic [2:0]                         state_o,
   output logic [clog2(LINES_PER_FRAME)-1:0]  line_cnt_o,
   output logic                               underrun_o
);

   localparam int unsigned WORD_W = clog2(WORDS_PER_LINE);
   localparam int unsigned LINE_W = clog2(LINES_PER_FRAME);

   state_t              state;
   logic                inv;
   logic                pop;
   logic                word_term;
   logic                line_term;
   logic [WORD_W-1:0]   unused_word_cnt;

   assign pop             = (state == ST_STREAM) && !fifo_empty_i;
   assign get_next_word_o = pop;
   assign sync_o          = (state == ST_SYNC);
   assign update_o        = (state == ST_UPDATE);
   assign state_o         = state;

   // Only the terminal flag of the word counter steers the FSM.
   bluejay_counter #(.MODULO(WORDS_PER_LINE), .W(WORD_W)) u_word_cnt (
      .clk   (clk_i),
      .rst   (reset_i),
      .clr   (state == ST_SYNC),
      .en    (pop),
      .count (unused_word_cnt),
      .term  (word_term)
   );

   bluejay_counter #(.MODULO(LINES_PER_FRAME), .W(LINE_W)) u_line_cnt (
      .clk   (clk_i),
      .rst   (reset_i),
      .clr   ((state == ST_IDLE) && new_frame_i),
      .en    ((state == ST_LINE_END) && !line_term),
      .count (line_cnt_o),
      .term  (line_term)
   );

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state      <= ST_IDLE;
         inv        <= 1'b0;
         data_o     <= '0;
         valid_o    <= 1'b0;
         underrun_o <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (new_frame_i) begin
                  inv        <= invert_i;
                  underrun_o <= 1'b0;
                  state      <= ST_WAIT_LINE;
               end
            end
            ST_WAIT_LINE: begin
               if (next_line_rdy_i) state <= ST_SYNC;
            end
            ST_SYNC: state <= ST_STREAM;
            ST_STREAM: begin
               if (!fifo_empty_i) begin
                  data_o  <= data_i ^ {DATA_W{inv}};
                  valid_o <= 1'b1;
                  if (word_term) state <= ST_LINE_END;
               end else begin
                  underrun_o <= 1'b1;
               end
            end
            ST_LINE_END: state <= line_term ? ST_UPDATE : ST_WAIT_LINE;
            ST_UPDATE:   state <= ST_IDLE;
            default:     state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bluejay_stream.sv
// Randomized frame-level bench for bluejay_stream with a queue-based FIFO and output model.
module tb_bluejay_stream;

   localparam int unsigned DW  = 32;
   localparam int unsigned WPL = 4;
   localparam int unsigned LPF = 2;
   localparam int unsigned NW  = WPL * LPF;

   logic          clk = 1'b0;
   logic          reset_i;
   logic          new_frame_i;
   logic          invert_i;
   logic [DW-1:0] data_i;
   logic          fifo_empty_i;
   logic          next_line_rdy_i;
   logic          get_next_word_o;
   logic [DW-1:0] data_o;
   logic          valid_o;
   logic          sync_o;
   logic          update_o;
   logic [2:0]    state_o;
   logic [0:0]    line_cnt_o;
   logic          underrun_o;

   bluejay_stream #(.DATA_W(DW), .WORDS_PER_LINE(WPL), .LINES_PER_FRAME(LPF)) dut (
      .clk_i           (clk),
      .reset_i         (reset_i),
      .new_frame_i     (new_frame_i),
      .invert_i        (invert_i),
      .data_i          (data_i),
      .fifo_empty_i    (fifo_empty_i),
      .next_line_rdy_i (next_line_rdy_i),
      .get_next_word_o (get_next_word_o),
      .data_o          (data_o),
      .valid_o         (valid_o),
      .sync_o          (sync_o),
      .update_o        (update_o),
      .state_o         (state_o),
      .line_cnt_o      (line_cnt_o),
      .underrun_o      (underrun_o)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] words[NW];
   int popped, n_valid, n_sync, n_upd, n_wait, gap;
   int stall_at, stall_len, stall_left, pace_left, nf_at;
   bit stall_done, pace, pace_done, flip, nf_done;

   // One clock: note a pop before the edge, observe outputs after it, then drive next inputs.
   task automatic cycle();
      logic          pop_now;
      logic [DW-1:0] e;
      @(negedge clk);
      pop_now = get_next_word_o;
      @(posedge clk);
      #1;
      if (pop_now) begin
         if (fifo_q.size() > 0) void'(fifo_q.pop_front());
         popped++;
      end
      if (sync_o)   n_sync++;
      if (update_o) n_upd++;
      if (state_o == 3'd1 && popped == WPL) n_wait++;
      if (valid_o) begin
         n_valid++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("data", data_o, e);
         end else begin
            check("extra_word", valid_o, 0);
         end
      end else if (n_valid == stall_at) begin
         gap++;
      end
      if (!stall_done && stall_len > 0 && popped == stall_at) begin
         stall_left = stall_len;
         stall_done = 1;
      end
      if (pace && !pace_done && popped == WPL) begin
         pace_left = 10;
         pace_done = 1;
      end
      fifo_empty_i = (fifo_q.size() == 0) || (stall_left > 0);
      if (stall_left > 0) stall_left--;
      data_i = (fifo_q.size() > 0) ? fifo_q[0] : DW'($urandom());
      next_line_rdy_i = (pace_left == 0);
      if (pace_left > 0) pace_left--;
      new_frame_i = (nf_at >= 0) && !nf_done && (popped == nf_at);
      if (new_frame_i) nf_done = 1;
      if (flip) invert_i = 1'($urandom_range(0, 1));
   endtask

   task automatic setup_frame(input bit inv, input int s_at, input int s_len,
                              input bit pc, input bit fl, input int nf);
      fifo_q.delete();
      exp_q.delete();
      for (int i = 0; i < NW; i++) begin
         fifo_q.push_back(words[i]);
         exp_q.push_back(words[i] ^ (inv ? 32'hFFFF_FFFF : 32'h0));
      end
      fifo_q.push_back(DW'($urandom()));
      fifo_q.push_back(DW'($urandom()));
      popped = 0; n_valid = 0; n_sync = 0; n_upd = 0; n_wait = 0; gap = 0;
      stall_at = s_at; stall_len = s_len; stall_left = 0; stall_done = 0;
      pace = pc; pace_done = 0; pace_left = 0; flip = fl; nf_at = nf; nf_done = 0;
      data_i = fifo_q[0];
      fifo_empty_i = 1'b0;
      next_line_rdy_i = 1'b1;
      invert_i = inv;
      new_frame_i = 1'b1;
      cycle();
      check("start_state", state_o, 1);
      check("start_line", line_cnt_o, 0);
      check("start_underrun", underrun_o, 0);
   endtask

   task automatic run_frame(input bit inv, input int s_at, input int s_len,
                            input bit pc, input bit fl, input int nf);
      int post;
      setup_frame(inv, s_at, s_len, pc, fl, nf);
      post = 0;
      for (int c = 0; c < 400 && post < 4; c++) begin
         cycle();
         if (n_upd > 0) post++;
      end
      check("frame_done", post >= 4, 1);
      check("valid_cnt", n_valid, NW);
      check("sync_cnt", n_sync, LPF);
      check("update_cnt", n_upd, 1);
      check("underrun", underrun_o, s_len > 0);
      check("stall_gap", gap, s_len);
      check("wait_cycles", n_wait, pc ? 10 : 1);
      check("spare_left", fifo_q.size(), 2);
      check("end_state", state_o, 0);
      check("end_line", line_cnt_o, LPF - 1);
      check("end_valid", valid_o, 0);
   endtask

   task automatic random_words();
      for (int i = 0; i < NW; i++) words[i] = DW'($urandom()) | 32'h1;
   endtask

   initial begin
      int s_at_tbl[6] = '{1, 2, 3, 5, 6, 7};
      int c;
      reset_i = 1'b1; new_frame_i = 1'b0; invert_i = 1'b0; data_i = '0;
      fifo_empty_i = 1'b1; next_line_rdy_i = 1'b1;
      flip = 0; nf_at = -1; stall_at = -1; stall_len = 0; pace = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_state", state_o, 0);
      check("rst_data", data_o, 0);
      check("rst_valid", valid_o, 0);
      check("rst_sync", sync_o, 0);
      check("rst_update", update_o, 0);
      check("rst_line", line_cnt_o, 0);
      check("rst_underrun", underrun_o, 0);
      check("rst_pop", get_next_word_o, 0);
      reset_i = 1'b0;

      // Clean frame of 1..8.
      for (int i = 0; i < NW; i++) words[i] = 32'(i + 1);
      run_frame(0, 2, 0, 0, 0, -1);

      // Inverted frame with invert_i toggling after the start.
      random_words();
      words[0] = 32'h0000_FFFF;
      run_frame(1, 2, 0, 0, 1, -1);

      // Three-cycle underrun after word 2.
      random_words();
      run_frame(0, 2, 3, 0, 0, -1);

      // Panel not ready for 10 cycles after line 0.
      random_words();
      run_frame(0, 2, 0, 1, 0, -1);

      // Frame request mid-stream is ignored.
      random_words();
      run_frame(0, 2, 0, 0, 0, 5);

      // Reset at word 2 of line 1, then a fresh frame.
      random_words();
      setup_frame(0, -1, 0, 0, 0, -1);
      c = 0;
      while (popped < WPL + 2 && c < 200) begin
         cycle();
         c++;
      end
      check("reset_reach", popped, WPL + 2);
      reset_i = 1'b1;
      #1;
      check("abort_state", state_o, 0);
      check("abort_data", data_o, 0);
      check("abort_valid", valid_o, 0);
      check("abort_sync", sync_o, 0);
      check("abort_update", update_o, 0);
      check("abort_line", line_cnt_o, 0);
      check("abort_pop", get_next_word_o, 0);
      cycle();
      cycle();
      check("abort_nopop", popped, WPL + 2);
      reset_i = 1'b0;
      cycle();
      check("abort_idle", state_o, 0);
      random_words();
      run_frame(0, 2, 0, 0, 0, -1);

      for (int f = 0; f < 6; f++) begin
         random_words();
         run_frame(1'($urandom_range(0, 1)),
                   s_at_tbl[$urandom_range(0, 5)],
                   int'($urandom_range(0, 4)),
                   1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)),
                   ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : -1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
